// File: rtl/enemy_direction_gen.sv
// Autonomous enemy direction driver: LFSR-timed walks/pauses on player-style key lines plus a periodic bomb strobe.
// Optional chase steering toward the target is enabled with the ENEMY_CHASE_EN macro.
module enemy_direction_gen #(
    parameter logic [15:0] SEED               = 16'hACE1,
    parameter int          MIN_RUN_FRAMES     = 16,
    parameter logic [5:0]  RUN_MASK           = 6'h1F,
    parameter int          PAUSE_FRAMES       = 8,
    parameter int          BOMB_PERIOD_FRAMES = 120
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               collision,
    input  logic [2:0]         HitEdgeCode,
    input  logic signed [10:0] selfX,
    input  logic signed [10:0] selfY,
    input  logic signed [10:0] targetX,
    input  logic signed [10:0] targetY,
    output logic               up_direction_key,
    output logic               down_direction_key,
    output logic               left_direction_key,
    output logic               right_direction_key,
    output logic               drop_bomb
);

    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [8:0]  MIN_RUN   = 9'(MIN_RUN_FRAMES);
    localparam logic [7:0]  PAUSE_LD  = 8'(PAUSE_FRAMES);
    localparam logic [9:0]  BOMB_LAST = 10'(BOMB_PERIOD_FRAMES - 1);

    typedef enum logic [1:0] {IDLE_ST, CHOOSE_ST, WALK_ST, PAUSE_ST} state_t;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [1:0]  r_dir;
    logic [1:0]  r_blocked_dir;
    logic        r_blocked;
    logic        r_hit_pend;
    logic [8:0]  r_run_cnt;
    logic [7:0]  r_pause_cnt;
    logic [9:0]  r_bomb_cnt;
    logic [3:0]  r_keys;
    logic        r_bomb;

    logic [15:0] w_lfsr_next;
    logic        w_edge_match;
    logic        w_hit;
    logic [1:0]  w_rand_dir;
    logic [1:0]  w_new_dir;
    logic [8:0]  w_run_load;

    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    // Corner hits (code 4) block every direction; other codes block only the side being walked into.
    always_comb begin
        w_edge_match = 1'b0;
        case (r_dir)
            2'd0: w_edge_match = (HitEdgeCode == 3'd3) || (HitEdgeCode == 3'd4);
            2'd1: w_edge_match = (HitEdgeCode == 3'd0) || (HitEdgeCode == 3'd4);
            2'd2: w_edge_match = (HitEdgeCode == 3'd1) || (HitEdgeCode == 3'd4);
            2'd3: w_edge_match = (HitEdgeCode == 3'd2) || (HitEdgeCode == 3'd4);
            default: w_edge_match = 1'b0;
        endcase
    end

    assign w_hit      = r_hit_pend | (collision & w_edge_match);
    assign w_rand_dir = (r_blocked && (r_lfsr[1:0] == r_blocked_dir)) ? (r_lfsr[1:0] + 2'd1) : r_lfsr[1:0];
    assign w_run_load = MIN_RUN + {3'b000, r_lfsr[7:2] & RUN_MASK};

`ifdef ENEMY_CHASE_EN
    logic signed [11:0] w_dx;
    logic signed [11:0] w_dy;
    logic [11:0]        w_adx;
    logic [11:0]        w_ady;
    logic [1:0]         w_chase_dir;

    assign w_dx  = {targetX[10], targetX} - {selfX[10], selfX};
    assign w_dy  = {targetY[10], targetY} - {selfY[10], selfY};
    assign w_adx = w_dx[11] ? 12'(-w_dx) : 12'(w_dx);
    assign w_ady = w_dy[11] ? 12'(-w_dy) : 12'(w_dy);
    assign w_chase_dir = (w_adx >= w_ady) ? ((w_dx > 12'sd0) ? 2'd3 : 2'd2)
                                          : ((w_dy > 12'sd0) ? 2'd1 : 2'd0);
    assign w_new_dir = ((r_blocked && (w_chase_dir == r_blocked_dir)) || (w_dx == 12'sd0 && w_dy == 12'sd0))
                       ? w_rand_dir : w_chase_dir;
`else
    logic w_unused_chase;
    assign w_unused_chase = ^{selfX, selfY, targetX, targetY};
    assign w_new_dir      = w_rand_dir;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_lfsr <= SEED_EFF;
        end else if (startOfFrame) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // Bomb cadence is frame-based and independent of the walk state, apart from idling before the first frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_bomb_cnt <= '0;
            r_bomb     <= 1'b0;
        end else begin
            r_bomb <= 1'b0;
            if (startOfFrame && (r_state != IDLE_ST)) begin
                if (r_bomb_cnt == BOMB_LAST) begin
                    r_bomb_cnt <= '0;
                    r_bomb     <= 1'b1;
                end else begin
                    r_bomb_cnt <= r_bomb_cnt + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= IDLE_ST;
            r_dir         <= 2'd0;
            r_blocked_dir <= 2'd0;
            r_blocked     <= 1'b0;
            r_hit_pend    <= 1'b0;
            r_run_cnt     <= '0;
            r_pause_cnt   <= '0;
            r_keys        <= '0;
        end else begin
            case (r_state)
                IDLE_ST: begin
                    r_keys <= '0;
                    if (startOfFrame) r_state <= CHOOSE_ST;
                end
                CHOOSE_ST: begin
                    r_dir      <= w_new_dir;
                    r_run_cnt  <= w_run_load;
                    r_blocked  <= 1'b0;
                    r_hit_pend <= 1'b0;
                    r_keys     <= 4'(4'b0001 << w_new_dir);
                    r_state    <= WALK_ST;
                end
                WALK_ST: begin
                    if (startOfFrame) begin
                        // A hit in the ending frame wins over run expiry.
                        if (w_hit) begin
                            r_blocked     <= 1'b1;
                            r_blocked_dir <= r_dir;
                            r_hit_pend    <= 1'b0;
                            r_keys        <= '0;
                            r_pause_cnt   <= PAUSE_LD;
                            r_state       <= PAUSE_ST;
                        end else if (r_run_cnt <= 9'd1) begin
                            r_run_cnt   <= '0;
                            r_keys      <= '0;
                            r_pause_cnt <= PAUSE_LD;
                            r_state     <= PAUSE_ST;
                        end else begin
                            r_run_cnt <= r_run_cnt - 9'd1;
                        end
                    end else if (w_hit) begin
                        r_hit_pend <= 1'b1;
                    end
                end
                PAUSE_ST: begin
                    r_keys <= '0;
                    if (startOfFrame) begin
                        if (r_pause_cnt <= 8'd1) begin
                            r_pause_cnt <= '0;
                            r_state     <= CHOOSE_ST;
                        end else begin
                            r_pause_cnt <= r_pause_cnt - 8'd1;
                        end
                    end
                end
                default: r_state <= IDLE_ST;
            endcase
        end
    end

    assign up_direction_key    = r_keys[0];
    assign down_direction_key  = r_keys[1];
    assign left_direction_key  = r_keys[2];
    assign right_direction_key = r_keys[3];
    assign drop_bomb           = r_bomb;

endmodule
